uart_tx_core: RTL and testbench

UART_TX_CORE -- requirements
Module: uart_tx_core

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_core.sv | 154 +++++++++++++++
 tb/tb_uart_tx_core.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and the transmitter state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   DBIT_DEF    - default data bits per frame
//   SB_TICK_DEF - default stop-bit length in s_ticks (16 = one stop bit)
//   OVERSAMPLE  - s_ticks per start/data bit
//   tx_state_e  - transmitter FSM states
package uart_pkg;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int OVERSAMPLE  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_core.sv
// UART transmitter: serialises din as start bit, DBIT data bits LSB first, stop bit.
// Latency: tx falls on the first clk edge after an accepted tx_start.
// Backpressure: tx_start is only honoured in IDLE; requests while tx_busy are dropped.
//
// Ports:
//   clk          - system clock, rising edge
//   rst_n        - synchronous active-low reset
//   s_tick       - 16x baud enable, one clk wide
//   tx_start     - request to send din (sampled only when idle)
//   din          - data word to send, LSB first
//   tx           - registered serial line, idle high
//   tx_done_tick - one-clk pulse in the last s_tick of the stop bit
//   tx_busy      - high while a frame is in flight
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_done_tick,
  output logic            tx_busy
);

  // The tick counter spans both the 16-tick data bits and a possibly longer
  // stop bit, so it is sized for whichever is larger.
  localparam int S_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int SW    = $clog2(S_MAX);
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

  tx_state_e       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            done;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state and datapath update. Everything holds unless s_tick is
  // present, except the IDLE->START hand-off which happens on tx_start alone;
  // an s_tick coinciding with that hand-off is deliberately not counted so the
  // start bit is always a full 16 ticks.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          state_d = START;
          s_d     = '0;
          b_d     = din;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = {1'b0, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            state_d = IDLE;
            done    = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The line is registered from the next state so it switches on the same
  // edge as the FSM; in DATA it follows the (possibly just shifted) LSB.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign tx_done_tick = done;
  assign tx_busy      = (state_q != IDLE);

  // The done pulse is always followed by IDLE, so it cannot repeat.
  a_done_single : assert property (
    @(posedge clk) disable iff (!rst_n) tx_done_tick |=> !tx_done_tick);

  // The line idles high.
  a_idle_high : assert property (
    @(posedge clk) disable iff (!rst_n) (state_q == IDLE) |-> tx_q);

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: directed frame table, multi-cycle
// corner sequences, and randomized traffic against a tick-count frame model.
`timescale 1ns/1ps
module tb_uart_tx_core;

  localparam int TOTAL = 16 * (1 + 8) + 16;  // s_ticks per frame, default DUT

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, s_tick, tx_start;
  logic [7:0] din;
  logic       tx, tx_done_tick, tx_busy;

  logic       s_tick32, tx_start32;
  logic [7:0] din32;
  logic       tx32, done32, busy32;

  uart_tx_core dut (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .tx_start(tx_start), .din(din),
    .tx(tx), .tx_done_tick(tx_done_tick), .tx_busy(tx_busy)
  );

  uart_tx_core #(.DBIT(8), .SB_TICK(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick32), .tx_start(tx_start32), .din(din32),
    .tx(tx32), .tx_done_tick(done32), .tx_busy(busy32)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a frame is just a count of s_ticks since it started.
  bit         m_busy = 1'b0;
  int         m_cnt  = 0;
  logic [7:0] m_data = 8'h00;

  logic smp_tx, smp_busy, smp_done, smp32_tx, smp32_busy, smp32_done;
  int   div = 1;
  int   ph  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Line level c s_ticks into a frame: start bit, 8 data bits LSB first, stop.
  function automatic logic line_of(input int c, input logic [7:0] d);
    int idx;
    idx = c / 16;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    return 1'b1;
  endfunction

  // One clock: compare outputs mid-cycle against the model, then advance the
  // model on the rising edge using the inputs that were applied.
  task automatic step();
    logic exp_tx, exp_done;
    @(negedge clk);
    smp_tx     = tx;
    smp_busy   = tx_busy;
    smp_done   = tx_done_tick;
    smp32_tx   = tx32;
    smp32_busy = busy32;
    smp32_done = done32;
    exp_tx   = m_busy ? line_of(m_cnt, m_data) : 1'b1;
    exp_done = m_busy && s_tick && (m_cnt == TOTAL - 1);
    check("model_tx", tx, exp_tx);
    check("model_busy", tx_busy, m_busy);
    check("model_done", tx_done_tick, exp_done);
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (tx_start) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        m_data = din;
      end
    end else if (s_tick) begin
      m_cnt++;
      if (m_cnt == TOTAL) m_busy = 1'b0;
    end
    #1;
  endtask

  // Periodic baud enable: s_tick in the last clk of every div-clk period.
  task automatic step_div();
    s_tick = (ph == div - 1);
    step();
    ph = (ph + 1) % div;
  endtask

  // Send one frame with the tick phase aligned so every bit is 16*d clks,
  // optionally poking tx_start/din mid-frame, and check the line shape.
  task automatic send_frame(input string tag, input logic [7:0] data, input int d,
                            input int inj_at, input logic [7:0] inj_din,
                            input logic [9:0] exp_bits, input int exp_frame);
    int busy_cnt, done_cnt, done_at;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    div = d;
    ph  = d - 1;      // coincident s_tick on the accepting cycle
    din = data;
    tx_start = 1'b1;
    step_div();
    tx_start = 1'b0;
    for (int c = 0; c < exp_frame + 4; c++) begin
      tx_start = (c == inj_at);
      if (c == inj_at) din = inj_din;
      step_div();
      if (smp_busy) busy_cnt++;
      if (smp_done) begin
        done_cnt++;
        done_at = c;
      end
      if (c == 16 * d - 1) check({tag, "_start_last"}, smp_tx, 1'b0);
      if ((c % (16 * d) == 8 * d) && (c / (16 * d) < 10))
        check({tag, "_bit"}, smp_tx, exp_bits[c / (16 * d)]);
    end
    tx_start = 1'b0;
    check({tag, "_busy_clks"}, busy_cnt, exp_frame);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_at"}, done_at, exp_frame - 1);
  endtask

  typedef struct {
    logic [7:0] din;
    int         div;
    int         inj_at;
    logic [7:0] inj_din;
    logic [9:0] exp_bits;   // bit 0 = start bit, bit 9 = stop bit
    int         exp_frame;  // clks with tx_busy high
  } vec_t;

  vec_t tbl[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{din: 8'hA5, div: 4, inj_at: -1,  inj_din: 8'h00, exp_bits: 10'h34A, exp_frame: 640};
    tbl[1] = '{din: 8'h3C, div: 2, inj_at: 101, inj_din: 8'h00, exp_bits: 10'h278, exp_frame: 320};
    tbl[2] = '{din: 8'h00, div: 1, inj_at: -1,  inj_din: 8'h00, exp_bits: 10'h200, exp_frame: 160};
    tbl[3] = '{din: 8'hFF, div: 3, inj_at: -1,  inj_din: 8'h00, exp_bits: 10'h3FE, exp_frame: 480};
    tbl[4] = '{din: 8'h5A, div: 2, inj_at: 40,  inj_din: 8'hC3, exp_bits: 10'h2B4, exp_frame: 320};

    rst_n = 1'b0; s_tick = 1'b0; tx_start = 1'b0; din = 8'h00;
    s_tick32 = 1'b0; tx_start32 = 1'b0; din32 = 8'h00;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with tx_start asserted to show it is ignored in reset.
    tx_start = 1'b1;
    step();
    check("reset_tx", smp_tx, 1'b1);
    check("reset_busy", smp_busy, 1'b0);
    check("reset_done", smp_done, 1'b0);
    check("reset_tx32", smp32_tx, 1'b1);
    tx_start = 1'b0;
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++)
      send_frame($sformatf("vec%0d", i), tbl[i].din, tbl[i].div, tbl[i].inj_at,
                 tbl[i].inj_din, tbl[i].exp_bits, tbl[i].exp_frame);

    // Back-to-back frames with tx_start held: one idle clk between them.
    begin
      int busy_cnt, done_cnt, gap;
      busy_cnt = 0; done_cnt = 0; gap = 0;
      div = 1; ph = 0;
      din = 8'h00; tx_start = 1'b1;
      step_div();
      for (int c = 0; c < 400; c++) begin
        step_div();
        if (smp_busy) busy_cnt++;
        else if (done_cnt == 1) begin
          gap++;
          check("b2b_gap_tx", smp_tx, 1'b1);
          tx_start = 1'b0;
        end
        if (smp_done) begin
          done_cnt++;
          if (done_cnt == 1) din = 8'hFF;
        end
      end
      check("b2b_busy_clks", busy_cnt, 320);
      check("b2b_done_cnt", done_cnt, 2);
      check("b2b_gap", gap, 1);
    end

    // Reset in the middle of data bit 3 of 0x55.
    begin
      int done_cnt;
      done_cnt = 0;
      div = 1; ph = 0;
      din = 8'h55; tx_start = 1'b1;
      step_div();
      tx_start = 1'b0;
      for (int c = 0; c < 16 * 4 + 8; c++) begin
        step_div();
        if (smp_done) done_cnt++;
      end
      rst_n = 1'b0;
      step_div();
      if (smp_done) done_cnt++;
      rst_n = 1'b1;
      step_div();
      check("midrst_tx", smp_tx, 1'b1);
      check("midrst_busy", smp_busy, 1'b0);
      for (int c = 0; c < 200; c++) begin
        step_div();
        if (smp_done) done_cnt++;
      end
      check("midrst_done_cnt", done_cnt, 0);
      send_frame("after_rst", 8'h81, 1, -1, 8'h00, 10'h302, 160);
    end

    // Two-stop-bit instance: 0x01 with s_tick every clk.
    begin
      int busy_cnt, done_cnt, high_run, done_at;
      busy_cnt = 0; done_cnt = 0; high_run = 0; done_at = -1;
      s_tick = 1'b0;
      s_tick32 = 1'b1; din32 = 8'h01; tx_start32 = 1'b1;
      step();
      tx_start32 = 1'b0;
      for (int c = 0; c < 200; c++) begin
        step();
        if (smp32_busy) begin
          busy_cnt++;
          if (smp32_tx) high_run++;
          else high_run = 0;
        end
        if (smp32_done) begin
          done_cnt++;
          done_at = c;
        end
      end
      s_tick32 = 1'b0;
      check("sb32_busy_clks", busy_cnt, 176);
      check("sb32_stop_clks", high_run, 32);
      check("sb32_done_cnt", done_cnt, 1);
      check("sb32_done_at", done_at, 175);
    end

    // Randomized traffic with varying tick density and occasional reset.
    for (int i = 0; i < 4500; i++) begin
      case ((i / 1500) % 3)
        0:       s_tick = 1'b1;
        1:       s_tick = ($urandom_range(0, 1) == 0);
        default: s_tick = ($urandom_range(0, 3) == 0);
      endcase
      tx_start = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) din = 8'($urandom);
      rst_n = ($urandom_range(0, 699) != 0);
      step();
    end
    rst_n = 1'b1;
    tx_start = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
